// File: rtl/flash_spi_read_engine_if.sv
// Request/response and SPI pad bundle for the flash read engine.
// slave = the engine, master = the requester plus the flash pads it faces.
interface flash_spi_read_engine_if;
  // read_rq is level-held; the engine acts only on its rising edge and samples
  // read_addr/read_size on that cycle. No ready: an edge during busy is queued
  // (one deep, newest wins), and read_end marks the final read_data_word.
  logic        read_rq;
  logic [23:0] read_addr;
  logic [9:0]  read_size;
  logic [7:0]  read_data;
  logic        read_data_vld;
  logic [31:0] read_data_word;
  logic        read_end;
  logic        busy;
  logic        spi_cs;
  logic        spi_clk;
  logic        mosi;
  logic        miso;

  modport slave (
    input  read_rq, read_addr, read_size, miso,
    output read_data, read_data_vld, read_data_word, read_end, busy,
           spi_cs, spi_clk, mosi
  );

  modport master (
    output read_rq, read_addr, read_size, miso,
    input  read_data, read_data_vld, read_data_word, read_end, busy,
           spi_cs, spi_clk, mosi
  );
endinterface

// File: rtl/flash_spi_read_engine.sv
// SPI NOR READ engine (mode 0), little-endian word assembly for the AHB boot path.
// Define FLASH_FAST_READ_EN for opcode 0x0B with 8 dummy clocks.
module flash_spi_read_engine #(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 4
) (
  input  logic                    HCLK,
  input  logic                    HRST_n,
  flash_spi_read_engine_if.slave  bus,
  output logic [2:0]              state_dbg
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_GAP} state_t;

`ifdef FLASH_FAST_READ_EN
  localparam logic [7:0] OPCODE = 8'h0B;
  localparam state_t     POST_ADDR = S_DUMMY;
`else
  localparam logic [7:0] OPCODE = 8'h03;
  localparam state_t     POST_ADDR = S_DATA;
`endif

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = $clog2(CS_GAP + 1);

  state_t         state, state_nxt;
  logic [DW-1:0]  div_cnt;
  logic [4:0]     bit_cnt;
  logic [9:0]     byte_cnt;
  logic [31:0]    tx_sr;
  logic [7:0]     rx_sr;
  logic [1:0]     lane;
  logic [GW-1:0]  gap_cnt;
  logic           read_rq_d;
  logic           pend;
  logic [23:0]    pend_addr;
  logic [9:0]     pend_size;

  logic           tick, rise, fall, rq_edge, start, start_pend, xfer_done;
  logic [7:0]     rx_byte;
  logic [23:0]    start_addr;
  logic [9:0]     start_size;

  assign state_dbg = state;

  always_comb begin
    tick       = (div_cnt == DW'(CLK_DIV - 1));
    rise       = tick & ~bus.spi_clk;
    fall       = tick &  bus.spi_clk;
    rq_edge    = bus.read_rq & ~read_rq_d;
    rx_byte    = {rx_sr[6:0], bus.miso};
    state_nxt  = state;
    start      = 1'b0;
    start_pend = 1'b0;
    xfer_done  = 1'b0;
    case (state)
      S_IDLE:  if (rq_edge) begin start = 1'b1; state_nxt = S_CMD; end
      S_CMD:   if (fall && bit_cnt == 5'd7)  state_nxt = S_ADDR;
      S_ADDR:  if (fall && bit_cnt == 5'd23) state_nxt = POST_ADDR;
      S_DUMMY: if (fall && bit_cnt == 5'd7)  state_nxt = S_DATA;
      S_DATA:  if (fall && bit_cnt == 5'd7 && byte_cnt == 10'd1) begin
                 state_nxt = S_GAP;
                 xfer_done = 1'b1;
               end
      S_GAP:   if (gap_cnt == GW'(CS_GAP)) begin
                 if (pend) begin
                   start      = 1'b1;
                   start_pend = 1'b1;
                   state_nxt  = S_CMD;
                 end else begin
                   state_nxt  = S_IDLE;
                 end
               end
      default: state_nxt = S_IDLE;
    endcase
    start_addr = start_pend ? pend_addr : bus.read_addr;
    start_size = start_pend ? pend_size : bus.read_size;
  end

  always_ff @(posedge HCLK) begin
    if (!HRST_n) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge HCLK) begin
    // Tracked through reset so a level held across reset is not seen as a new edge.
    read_rq_d <= bus.read_rq;
    if (!HRST_n) begin
      div_cnt            <= '0;
      bit_cnt            <= '0;
      byte_cnt           <= '0;
      tx_sr              <= '0;
      rx_sr              <= '0;
      lane               <= '0;
      gap_cnt            <= '0;
      pend               <= 1'b0;
      pend_addr          <= '0;
      pend_size          <= '0;
      bus.read_data      <= '0;
      bus.read_data_vld  <= 1'b0;
      bus.read_data_word <= '0;
      bus.read_end       <= 1'b0;
      bus.busy           <= 1'b0;
      bus.spi_cs         <= 1'b1;
      bus.spi_clk        <= 1'b0;
      bus.mosi           <= 1'b0;
    end else begin
      bus.read_data_vld <= 1'b0;
      bus.read_end      <= 1'b0;
      if (start) begin
        tx_sr       <= {OPCODE, start_addr};
        byte_cnt    <= (start_size == 10'd0) ? 10'd1 : start_size;
        div_cnt     <= '0;
        bit_cnt     <= '0;
        lane        <= '0;
        gap_cnt     <= '0;
        bus.busy    <= 1'b1;
        bus.spi_cs  <= 1'b0;
        bus.spi_clk <= 1'b0;
        bus.mosi    <= OPCODE[7];
      end else if (state == S_CMD || state == S_ADDR || state == S_DUMMY || state == S_DATA) begin
        div_cnt <= tick ? '0 : div_cnt + DW'(1);
        // miso is captured on the same HCLK edge that raises spi_clk.
        if (rise) begin
          bus.spi_clk <= 1'b1;
          if (state == S_DATA) begin
            rx_sr <= rx_byte;
            if (bit_cnt == 5'd7) begin
              bus.read_data                   <= rx_byte;
              bus.read_data_vld               <= 1'b1;
              bus.read_data_word[lane*8 +: 8] <= rx_byte;
              lane                            <= lane + 2'd1;
            end
          end
        end
        if (fall) begin
          bus.spi_clk <= 1'b0;
          tx_sr       <= tx_sr << 1;
          bus.mosi    <= tx_sr[30];
          if (state_nxt != state || (state == S_DATA && bit_cnt == 5'd7)) bit_cnt <= '0;
          else                                                             bit_cnt <= bit_cnt + 5'd1;
          if (state == S_DATA && bit_cnt == 5'd7) byte_cnt <= byte_cnt - 10'd1;
          if (xfer_done) begin
            bus.spi_cs   <= 1'b1;
            bus.read_end <= 1'b1;
            bus.mosi     <= 1'b0;
            gap_cnt      <= '0;
          end
        end
      end else if (state == S_GAP) begin
        gap_cnt <= gap_cnt + GW'(1);
        if (gap_cnt == GW'(CS_GAP - 1)) bus.busy <= 1'b0;
      end
      // A fresh edge during a transaction (including the final gap cycle) wins over a consumed one.
      if (start_pend) pend <= 1'b0;
      if (rq_edge && state != S_IDLE) begin
        pend      <= 1'b1;
        pend_addr <= bus.read_addr;
        pend_size <= bus.read_size;
      end
    end
  end

endmodule

// File: tb/tb_flash_spi_read_engine.sv
// Scoreboard bench for flash_spi_read_engine: directed reads against a behavioural SPI flash.
module tb_flash_spi_read_engine;

  localparam int CLK_DIV = 2;
  localparam int CS_GAP  = 4;
`ifdef FLASH_FAST_READ_EN
  localparam logic [7:0] OP  = 8'h0B;
  localparam int         HDR = 40;
`else
  localparam logic [7:0] OP  = 8'h03;
  localparam int         HDR = 32;
`endif

  logic       HCLK = 1'b0;
  logic       HRST_n = 1'b0;
  logic [2:0] state_dbg;

  flash_spi_read_engine_if bus();

  flash_spi_read_engine #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .HCLK      (HCLK),
    .HRST_n    (HRST_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_hdr_q[$];
  logic [7:0]  exp_byte_q[$];
  logic [31:0] exp_word_q[$];
  int          exp_dur_q[$];
  logic [7:0]  mem [0:7];

  int          cs_falls = 0;
  int          cs_fall_cyc = 0;
  int          end_cyc = -1;
  int          rcnt = 0;
  int          idx;
  logic [31:0] hdr = '0;
  logic        prev_clk = 1'b0;
  logic        prev_cs = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT output with no expected entry (cycle %0d)", name, cyc);
  endtask

  // ---------------- flash model + monitor ----------------
  always @(negedge HCLK) begin
    if (prev_cs && !bus.spi_cs) begin
      cs_falls++;
      rcnt        = 0;
      hdr         = '0;
      cs_fall_cyc = cyc;
      if (end_cyc >= 0) check("cs_gap_min", 32'((cyc - end_cyc) >= CS_GAP + 1), 32'd1);
    end
    if (!bus.spi_cs && bus.spi_clk && !prev_clk) begin
      if (rcnt < 32) begin
        hdr = {hdr[30:0], bus.mosi};
        if (rcnt == 31) begin
          if (exp_hdr_q.size() == 0) unexpected("header");
          else                       check("header", hdr, exp_hdr_q.pop_front());
        end
      end
      rcnt++;
    end
    // Present the bit for the next rising spi_clk.
    if (!bus.spi_cs && rcnt >= HDR) begin
      idx      = rcnt - HDR;
      bus.miso = mem[(idx / 8) % 8][7 - (idx % 8)];
    end else begin
      bus.miso = 1'b0;
    end
    if (bus.read_data_vld) begin
      if (exp_byte_q.size() == 0) unexpected("data_byte");
      else                        check("data_byte", {24'd0, bus.read_data}, {24'd0, exp_byte_q.pop_front()});
    end
    if (bus.read_end) begin
      if (exp_word_q.size() == 0) begin
        unexpected("read_end");
      end else begin
        check("read_word", bus.read_data_word, exp_word_q.pop_front());
        check("end_latency", 32'(cyc - cs_fall_cyc), 32'(exp_dur_q.pop_front()));
        check("cs_high_at_end", {31'd0, bus.spi_cs}, 32'd1);
      end
      end_cyc = cyc;
    end
    prev_clk = bus.spi_clk;
    prev_cs  = bus.spi_cs;
  end

  // ---------------- driver tasks ----------------
  task automatic expect_xfer(input logic [23:0] a, input int n, input logic [31:0] word);
    exp_hdr_q.push_back({OP, a});
    for (int k = 0; k < n; k++) exp_byte_q.push_back(mem[k % 8]);
    exp_word_q.push_back(word);
    exp_dur_q.push_back(2 * CLK_DIV * (HDR + 8 * n));
  endtask

  task automatic issue(input logic [23:0] a, input logic [9:0] s);
    bus.read_rq = 1'b0;
    @(negedge HCLK);
    bus.read_addr = a;
    bus.read_size = s;
    bus.read_rq   = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge HCLK);
      if (exp_word_q.size() == 0 && !bus.busy) break;
    end
    check("done_within_budget", 32'(i < budget), 32'd1);
  endtask

  task automatic set_mem(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
    mem[0] = b0; mem[1] = b1; mem[2] = b2; mem[3] = b3;
    mem[4] = b4; mem[5] = b5; mem[6] = 8'h00; mem[7] = 8'h00;
  endtask

  // ---------------- stimulus ----------------
  int falls_snap;

  initial begin
    bus.read_rq   = 1'b0;
    bus.read_addr = '0;
    bus.read_size = '0;
    bus.miso      = 1'b0;
    set_mem(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (3) @(negedge HCLK);
    HRST_n = 1'b1;
    repeat (10) @(negedge HCLK);
    check("rst_spi_cs",  {31'd0, bus.spi_cs},  32'd1);
    check("rst_spi_clk", {31'd0, bus.spi_clk}, 32'd0);
    check("rst_busy",    {31'd0, bus.busy},    32'd0);
    check("rst_mosi",    {31'd0, bus.mosi},    32'd0);
    check("rst_data",    {24'd0, bus.read_data}, 32'd0);
    check("rst_word",    bus.read_data_word,   32'd0);
    check("rst_no_cs",   32'(cs_falls),        32'd0);

    // 4-byte read: first-cycle outputs, then scoreboard covers bytes/word/latency
    set_mem(8'h13, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    expect_xfer(24'h000100, 4, 32'h0000_0013);
    issue(24'h000100, 10'd4);
    @(negedge HCLK);
    check("acc_spi_cs", {31'd0, bus.spi_cs}, 32'd0);
    check("acc_busy",   {31'd0, bus.busy},   32'd1);
    check("acc_mosi",   {31'd0, bus.mosi},   {31'd0, OP[7]});
    wait_done(2000);

    // size 0 behaves as one byte; only lane 0 changes
    set_mem(8'hAB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    expect_xfer(24'hFFFFFF, 1, 32'h0000_00AB);
    issue(24'hFFFFFF, 10'd0);
    wait_done(2000);

    // 6 bytes wrap lanes 0 and 1
    set_mem(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66);
    expect_xfer(24'h000010, 6, 32'h4433_6655);
    issue(24'h000010, 10'd6);
    wait_done(2000);

    // second edge mid-transaction queues a follow-up read
    set_mem(8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00);
    expect_xfer(24'h000100, 4, 32'h0403_0201);
    expect_xfer(24'h000200, 4, 32'h0403_0201);
    issue(24'h000100, 10'd4);
    repeat (100) @(negedge HCLK);
    bus.read_rq = 1'b0;
    @(negedge HCLK);
    bus.read_addr = 24'h000200;
    bus.read_rq   = 1'b1;
    wait_done(3000);
    falls_snap = cs_falls;
    repeat (400) @(negedge HCLK);
    check("no_third_xfer", 32'(cs_falls - falls_snap), 32'd0);
    check("idle_after_pend", {31'd0, bus.busy}, 32'd0);

    // reset pulse during ADDR aborts cleanly
    issue(24'h000300, 10'd4);
    repeat (4 * CLK_DIV * 12) @(negedge HCLK);
    HRST_n = 1'b0;
    @(negedge HCLK);
    HRST_n = 1'b1;
    check("abort_spi_cs",  {31'd0, bus.spi_cs},  32'd1);
    check("abort_busy",    {31'd0, bus.busy},    32'd0);
    check("abort_spi_clk", {31'd0, bus.spi_clk}, 32'd0);
    check("abort_word",    bus.read_data_word,   32'd0);
    falls_snap = cs_falls;
    repeat (400) @(negedge HCLK);
    check("abort_no_restart", 32'(cs_falls - falls_snap), 32'd0);

    set_mem(8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00);
    expect_xfer(24'h000400, 2, 32'h0000_A55A);
    issue(24'h000400, 10'd2);
    wait_done(2000);
    bus.read_rq = 1'b0;
    repeat (20) @(negedge HCLK);

    check("hdr_q_empty",  32'(exp_hdr_q.size()),  32'd0);
    check("byte_q_empty", 32'(exp_byte_q.size()), 32'd0);
    check("word_q_empty", 32'(exp_word_q.size()), 32'd0);
    check("dur_q_empty",  32'(exp_dur_q.size()),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
